// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator feeding the pixel generator and the
// display sync pins. Counters advance one pixel per pix_en tick; all status
// outputs are registered from the next counter values so they line up with
// pixel_cnt/line_cnt in the same cycle.
//
// Optional macro VGA_SYNC_DELAY_EN: adds one pix_en-loaded register stage on
// h_sync, v_sync, video_on, line_start and frame_start. That stage makes them
// lag the counters by one pixel tick, matching a registered colour stage
// downstream.
//
// Handshake: none. pix_en is a qualifier only; when low, every register
// holds and the start pulses read 0.
module vga_timing_gen #(
  parameter int PIXEL_CTR_W = 9,
  parameter int LINE_CTR_W  = 9,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_SYNC_POL  = 0,
  parameter int V_SYNC_POL  = 0
) (
  input  logic                   rfr_clk,
  input  logic                   reset_n,
  input  logic                   pix_en,
  output logic [PIXEL_CTR_W:0]   pixel_cnt,
  output logic [LINE_CTR_W:0]    line_cnt,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   video_on,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int PW      = PIXEL_CTR_W + 1;
  localparam int LW      = LINE_CTR_W + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [PW-1:0] H_LAST    = PW'(H_TOTAL - 1);
  localparam logic [PW-1:0] H_VIS_END = PW'(H_ACTIVE);
  localparam logic [PW-1:0] HS_BEG    = PW'(H_ACTIVE + H_FP);
  localparam logic [PW-1:0] HS_END    = PW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LW-1:0] V_LAST    = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] V_VIS_END = LW'(V_ACTIVE);
  localparam logic [LW-1:0] VS_BEG    = LW'(V_ACTIVE + V_FP);
  localparam logic [LW-1:0] VS_END    = LW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);

  logic [PW-1:0] pixel_nxt;
  logic [LW-1:0] line_nxt;
  logic          video_nxt, hs_nxt, vs_nxt;
  logic          video_r, hs_r, vs_r;

  // Next raster position and the decodes of that position.
  always_comb begin
    pixel_nxt = pixel_cnt + 1'b1;
    line_nxt  = line_cnt;
    if (pixel_cnt == H_LAST) begin
      pixel_nxt = '0;
      line_nxt  = (line_cnt == V_LAST) ? '0 : line_cnt + 1'b1;
    end
    video_nxt = (pixel_nxt < H_VIS_END) && (line_nxt < V_VIS_END);
    hs_nxt    = (pixel_nxt >= HS_BEG) && (pixel_nxt < HS_END);
    vs_nxt    = (line_nxt >= VS_BEG) && (line_nxt < VS_END);
  end

  // Counter and status registers; reset parks on the last blanking pixel.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_cnt <= H_LAST;
      line_cnt  <= V_LAST;
      video_r   <= 1'b0;
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
    end else if (pix_en) begin
      pixel_cnt <= pixel_nxt;
      line_cnt  <= line_nxt;
      video_r   <= video_nxt;
      hs_r      <= hs_nxt;
      vs_r      <= vs_nxt;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic video_d, hs_d, vs_d, ls_d, fs_d;

  // One-tick delay stage; pulses come from the position held before this tick.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      video_d <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      ls_d    <= 1'b0;
      fs_d    <= 1'b0;
    end else if (pix_en) begin
      video_d <= video_r;
      hs_d    <= hs_r;
      vs_d    <= vs_r;
      ls_d    <= (pixel_cnt == '0);
      fs_d    <= (pixel_cnt == '0) && (line_cnt == '0);
    end else begin
      ls_d    <= 1'b0;
      fs_d    <= 1'b0;
    end
  end

  assign video_on    = video_d;
  assign h_sync      = hs_d ? HS_ON : ~HS_ON;
  assign v_sync      = vs_d ? VS_ON : ~VS_ON;
  assign line_start  = ls_d;
  assign frame_start = fs_d;
`else
  logic ls_r, fs_r;

  // Start pulses: high for the cycle after a tick that loads pixel_cnt = 0.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      ls_r <= 1'b0;
      fs_r <= 1'b0;
    end else if (pix_en) begin
      ls_r <= (pixel_nxt == '0);
      fs_r <= (pixel_nxt == '0) && (line_nxt == '0);
    end else begin
      ls_r <= 1'b0;
      fs_r <= 1'b0;
    end
  end

  assign video_on    = video_r;
  assign h_sync      = hs_r ? HS_ON : ~HS_ON;
  assign v_sync      = vs_r ? VS_ON : ~VS_ON;
  assign line_start  = ls_r;
  assign frame_start = fs_r;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel generator.
- Produces `pixel_cnt`, `line_cnt`, `h_sync`, `v_sync` and `video_on` for the pixel generator, and `h_sync`/`v_sync` for the display port.
- Runs on the refresh clock, advancing one pixel per `pix_en` tick.
- Defaults give 640x480 @ 60 Hz (800x525 total raster).

Parameters:
- PIXEL_CTR_W, 9, MSB index of pixel counter (counter is PIXEL_CTR_W+1 bits)
- LINE_CTR_W, 9, MSB index of line counter (counter is LINE_CTR_W+1 bits)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- H_SYNC_POL, 0, asserted level of `h_sync` (0 = active-low)
- V_SYNC_POL, 0, asserted level of `v_sync` (0 = active-low)

Ports:
- rfr_clk  input  1  refresh clock
- reset_n  input  1  asynchronous active-low reset
- pix_en  input  1  pixel tick; counters advance only when high
- pixel_cnt  output  PIXEL_CTR_W+1  horizontal position, 0..H_TOTAL-1
- line_cnt  output  LINE_CTR_W+1  vertical position, 0..V_TOTAL-1
- h_sync  output  1  horizontal sync, polarity set by H_SYNC_POL
- v_sync  output  1  vertical sync, polarity set by V_SYNC_POL
- video_on  output  1  high inside the active region
- line_start  output  1  one-cycle pulse when `pixel_cnt` becomes 0
- frame_start  output  1  one-cycle pulse when (`pixel_cnt`, `line_cnt`) becomes (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
  - Parameters must fit the counter widths; this is not checked in RTL.
- Reset values (asynchronous, `reset_n` = 0):
  - `pixel_cnt` = H_TOTAL-1, `line_cnt` = V_TOTAL-1 (last blanking pixel of the frame)
  - `video_on` = 0
  - `h_sync` = ~H_SYNC_POL, `v_sync` = ~V_SYNC_POL
  - `line_start` = 0, `frame_start` = 0
- Counting, on a `rfr_clk` rising edge with `pix_en` = 1:
  - `pixel_cnt` increments.
  - At H_TOTAL-1, `pixel_cnt` wraps to 0 and `line_cnt` increments.
  - When `line_cnt` is V_TOTAL-1 at that same wrap, `line_cnt` wraps to 0.
- With `pix_en` = 0: all outputs hold, and `line_start`/`frame_start` drop to 0.
- All status outputs are registered and computed from the next counter values. They therefore describe the current `pixel_cnt`/`line_cnt` in the same cycle: zero skew, no combinational glitch.
  - `video_on` = (`pixel_cnt` < H_ACTIVE) && (`line_cnt` < V_ACTIVE)
  - `h_sync` asserted iff H_ACTIVE+H_FP <= `pixel_cnt` < H_ACTIVE+H_FP+H_SYNC
  - `v_sync` asserted iff V_ACTIVE+V_FP <= `line_cnt` < V_ACTIVE+V_FP+V_SYNC; it is a whole-line decode and changes only on the edge where `pixel_cnt` wraps to 0.
  - `line_start` = 1 for exactly the one `rfr_clk` cycle following the edge that loaded `pixel_cnt` = 0.
  - `frame_start` = `line_start` && (`line_cnt` == 0).
  - Both pulses are 0 while counters are held by `pix_en` = 0.
- The first `pix_en` tick after reset loads (0,0) and pulses `frame_start` and `line_start` together.
- Reset asserted mid-frame: immediate return to reset values. No partial pulse; sync outputs go inactive at once.
- Simultaneous events:
  - Last pixel of the frame: both counters wrap on the same edge.
  - `line_start` and `frame_start` may be high together only at (0,0).
- `pix_en` held high continuously: one pixel per clock. `pix_en` must not be asserted during reset.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN
- Defined:
  - `h_sync`, `v_sync`, `video_on`, `line_start` and `frame_start` each pass through one extra register, loaded on `pix_en` ticks.
  - They lag `pixel_cnt`/`line_cnt` by exactly one pixel tick, matching a registered colour stage in the pixel generator.
  - Delay registers reset to the same inactive values as above.
  - `line_start`/`frame_start` remain single-cycle pulses.
- Undefined: zero-skew behaviour as specified in Behaviour.

Test Plan:
- Reset then `pix_en` = 1 constantly:
  - first edge gives `pixel_cnt` = 0, `line_cnt` = 0, `frame_start` = `line_start` = 1, `video_on` = 1
  - next cycle both pulses are 0
- Horizontal decode, defaults, free run:
  - `video_on` falls when `pixel_cnt` = 640
  - `h_sync` = 0 for `pixel_cnt` 656..751, 1 at 752
  - wrap 799 -> 0 increments `line_cnt`
- Vertical decode:
  - `v_sync` = 0 exactly for `line_cnt` 490..491
  - `video_on` = 0 for `line_cnt` >= 480
  - after (799,524) the next pixel is (0,0) with `frame_start` = 1
  - 420000 cycles between consecutive `frame_start` pulses
- `pix_en` toggled 1/0 every cycle:
  - counters advance every 2 cycles; 840000 clocks per frame
  - `line_start` is 1 for one cycle only per line
- Assert `reset_n` = 0 at (700,300) while `h_sync` is asserted:
  - outputs go immediately to (799,524), `h_sync` = 1, `video_on` = 0
- Bench compiled with VGA_SYNC_DELAY_EN:
  - `h_sync` falls one pixel tick after `pixel_cnt` = 656
  - `video_on` rises when `pixel_cnt` = 1 on line 0
